// File: rtl/led_pwm_frame_scheduler.sv
// led_pwm_frame_scheduler: shifts per-slot PWM on/off vectors into a TLC6C5912 chain and latches them
module led_pwm_frame_scheduler #(
  parameter int N_CH = 12,
  parameter int PWM_BITS = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [$clog2(N_CH)-1:0] wr_addr,
  input  logic [PWM_BITS-1:0]     wr_data,
  input  logic                    commit_req,
  output logic                    commit_ack,
  output logic                    frame_start,
  output logic                    busy,
  output logic                    SR_Q,
  output logic                    SR_CK,
  output logic                    SR_LATCH,
  output logic                    SR_G_B
);
  localparam int AW = $clog2(N_CH);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0] BIT_LAST = AW'(N_CH - 1);
  localparam logic [AW:0] N_LIM = (AW + 1)'(N_CH);
  localparam logic [PWM_BITS-1:0] SLOT_LAST = PWM_BITS'(2 ** PWM_BITS - 2);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;
  state_t state;
  logic [PWM_BITS-1:0] slot;
  logic [PWM_BITS-1:0] shadow [N_CH];
  logic [PWM_BITS-1:0] active [N_CH];
  logic [AW-1:0] bit_idx;
  logic [DW-1:0] div;
  logic [N_CH-1:0] vec, cmp;
  logic div_done, wr_ok, to_load, to_zero, copy;
  for (genvar c = 0; c < N_CH; c++) begin : g_cmp
    assign cmp[c] = active[c] > slot;
  end
  assign div_done = div == DIV_LAST;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < N_LIM);
  assign to_load = enable && (state == IDLE || (state == GAP && div_done));
  assign to_zero = state == IDLE || slot == SLOT_LAST;
  assign copy = to_load && to_zero && commit_req;
  // shadow takes host writes; active snapshots the pre-write shadow when a frame begins with a commit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      if (wr_ok) shadow[wr_addr] <= wr_data;
      if (copy) active <= shadow;
    end
  end
  // frame sequencer: outputs are registered on entry so they line up with the state they describe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      slot <= '0;
      bit_idx <= '0;
      div <= '0;
      vec <= '0;
      SR_Q <= 1'b0;
      SR_CK <= 1'b0;
      SR_LATCH <= 1'b0;
      SR_G_B <= 1'b1;
      commit_ack <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      div <= (div_done || state == IDLE || state == LOAD) ? '0 : div + 1'b1;
      commit_ack <= copy;
      frame_start <= to_load && to_zero;
      case (state)
        IDLE: if (enable) begin
          state <= LOAD;
          busy <= 1'b1;
        end
        LOAD: begin
          state <= SHIFT_LO;
          vec <= cmp;
          SR_Q <= cmp[N_CH-1];
          bit_idx <= BIT_LAST;
        end
        SHIFT_LO: if (div_done) begin
          state <= SHIFT_HI;
          SR_CK <= 1'b1;
        end
        SHIFT_HI: if (div_done) begin
          SR_CK <= 1'b0;
          if (bit_idx == '0) begin
            state <= LATCH;
            SR_LATCH <= 1'b1;
          end else begin
            state <= SHIFT_LO;
            bit_idx <= bit_idx - 1'b1;
            SR_Q <= vec[bit_idx - 1'b1];
          end
        end
        LATCH: if (div_done) begin
          state <= GAP;
          SR_LATCH <= 1'b0;
          SR_G_B <= 1'b0;
        end
        GAP: if (div_done) begin
          slot <= (!enable || slot == SLOT_LAST) ? '0 : slot + 1'b1;
          state <= enable ? LOAD : IDLE;
          busy <= enable;
          SR_G_B <= !enable;
          SR_Q <= enable ? SR_Q : 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_pwm_frame_scheduler.sv
// tb_led_pwm_frame_scheduler: directed and random steps checked against a slot-level PWM model of the chain
module tb_led_pwm_frame_scheduler;
  localparam int N = 12, SLOTS = 15, FRAME = 1575;
  logic CLK = 0, RESET = 1, enable = 0, wr_en = 0, commit_req = 0;
  logic [3:0] wr_addr = 0, wr_data = 0;
  logic commit_ack, frame_start, busy, SR_Q, SR_CK, SR_LATCH, SR_G_B;
  int vectors = 0, miscompares = 0;
  logic [3:0] shd_m [N];
  logic [3:0] act_m [N];
  logic [N-1:0] chain;
  logic [N-1:0] lat_vec [SLOTS];
  int cyc_n = 0, last_fs = 0, last_rise = 0, rises = 0, slot_m = 0, lat_in_frame = 0, run_lat = 0;
  bit fs_valid = 0, prev_ck = 0, prev_lat = 0;
  int k;

  led_pwm_frame_scheduler dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit_req(commit_req), .commit_ack(commit_ack),
    .frame_start(frame_start), .busy(busy), .SR_Q(SR_Q), .SR_CK(SR_CK),
    .SR_LATCH(SR_LATCH), .SR_G_B(SR_G_B)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // one clock: update the table model at the edge, then observe the pins as the external chain would
  task automatic cyc();
    logic [3:0] pre [N];
    logic [N-1:0] want;
    bit req_pre, rst_pre;
    pre = shd_m;
    req_pre = commit_req;
    rst_pre = RESET;
    @(posedge CLK);
    if (rst_pre) begin
      shd_m = '{default: '0};
      act_m = '{default: '0};
    end else if (wr_en && wr_addr < 4'd12) shd_m[wr_addr] = wr_data;
    @(negedge CLK);
    cyc_n++;
    if (rst_pre) begin
      chain = '0;
      rises = 0;
      slot_m = 0;
      lat_in_frame = 0;
      run_lat = 0;
      fs_valid = 0;
    end else begin
      if (frame_start || commit_ack) chk("commit_ack", 32'(commit_ack), 32'(frame_start && req_pre));
      if (frame_start && req_pre) act_m = pre;
      if (frame_start) begin
        if (fs_valid) begin
          chk("frame_period", cyc_n - last_fs, FRAME);
          chk("latches_per_frame", lat_in_frame, SLOTS);
        end
        fs_valid = 1;
        last_fs = cyc_n;
        slot_m = 0;
        lat_in_frame = 0;
      end
      if (SR_CK && !prev_ck) begin
        if (rises > 0) chk("ck_period", cyc_n - last_rise, 8);
        chain = {chain[N-2:0], SR_Q};
        last_rise = cyc_n;
        rises++;
      end
      if (SR_LATCH && !prev_lat) begin
        for (int i = 0; i < N; i++) want[i] = int'(act_m[i]) > slot_m;
        chk("bits_per_slot", rises, N);
        chk("slot_vector", 32'(chain), 32'(want));
        if (run_lat == 0) chk("gb_before_gap", 32'(SR_G_B), 1);
        if (slot_m < SLOTS) lat_vec[slot_m] = chain;
        rises = 0;
        slot_m++;
        lat_in_frame++;
        run_lat++;
      end
      if (!SR_LATCH && prev_lat) chk("gb_at_gap", 32'(SR_G_B), 0);
      if (!busy) begin
        fs_valid = 0;
        run_lat = 0;
      end
    end
    prev_ck = SR_CK;
    prev_lat = SR_LATCH;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en = 0;
  endtask

  task automatic run_fs(input int n);
    int seen = 0;
    for (int j = 0; j < n * 1700 && seen < n; j++) begin
      cyc();
      if (frame_start) seen++;
    end
    chk("frame_starts_seen", seen, n);
  endtask

  task automatic wait_ack(input string tag, output int cnt);
    cnt = 0;
    while (!commit_ack && cnt < 2000) begin
      cyc();
      cnt++;
    end
    chk(tag, 32'(commit_ack), 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sr_q", 32'(SR_Q), 0);
    chk("rst_sr_ck", 32'(SR_CK), 0);
    chk("rst_sr_latch", 32'(SR_LATCH), 0);
    chk("rst_sr_g_b", 32'(SR_G_B), 1);
    chk("rst_commit_ack", 32'(commit_ack), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) cyc();
    chk_reset_outputs();
    RESET = 0;
    cyc();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_g_b", 32'(SR_G_B), 1);
    // zero tables: blank frames, timing and output-enable sequencing
    enable = 1;
    cyc();
    chk("first_frame_start", 32'(frame_start), 1);
    chk("busy_running", 32'(busy), 1);
    run_fs(3);
    // directed duties
    wr(4'd0, 4'd15);
    wr(4'd11, 4'd1);
    wr(4'd5, 4'd8);
    commit_req = 1;
    wait_ack("ack_commit", k);
    commit_req = 0;
    run_fs(1);
    chk("vec_slot0", 32'(lat_vec[0]), 32'h821);
    chk("vec_slot1", 32'(lat_vec[1]), 32'h021);
    chk("vec_slot7", 32'(lat_vec[7]), 32'h021);
    chk("vec_slot8", 32'(lat_vec[8]), 32'h001);
    chk("vec_slot14", 32'(lat_vec[14]), 32'h001);
    // commit requested mid-frame waits for the next slot-0 load
    repeat (300) cyc();
    wr(4'd3, 4'd9);
    commit_req = 1;
    wait_ack("ack_midframe", k);
    commit_req = 0;
    chk("ack_midframe_wait", k, FRAME - 301);
    run_fs(1);
    chk("ch3_slot8", 32'(lat_vec[8][3]), 1);
    chk("ch3_slot9", 32'(lat_vec[9][3]), 0);
    // out-of-range write, then write and copy on the same edge
    wr(4'd12, 4'd15);
    wr(4'd7, 4'd6);
    run_fs(1);
    repeat (FRAME - 1) cyc();
    wr_en = 1;
    wr_addr = 4'd7;
    wr_data = 4'd13;
    commit_req = 1;
    cyc();
    wr_en = 0;
    commit_req = 0;
    chk("ack_same_cycle", 32'(commit_ack), 1);
    run_fs(1);
    chk("old_value_slot5", 32'(lat_vec[5][7]), 1);
    chk("old_value_slot6", 32'(lat_vec[6][7]), 0);
    chk("oob_slot0", 32'(lat_vec[0]), 32'h8a9);
    // random table
    for (int i = 0; i < N; i++) wr(4'(i), 4'($urandom_range(0, 15)));
    wr(4'($urandom_range(12, 15)), 4'($urandom_range(1, 15)));
    commit_req = 1;
    wait_ack("ack_random", k);
    commit_req = 0;
    run_fs(2);
    // enable drop during slot 3 shift
    run_fs(1);
    repeat (330) cyc();
    enable = 0;
    k = 0;
    while (busy && k < 500) begin
      cyc();
      k++;
    end
    chk("went_idle", 32'(busy), 0);
    chk("idle_delay", k, 90);
    chk("slots_completed", lat_in_frame, 4);
    chk("idle_g_b_after_drop", 32'(SR_G_B), 1);
    // restart, then reset in the middle of a shift high phase
    enable = 1;
    cyc();
    chk("restart_frame_start", 32'(frame_start), 1);
    k = 0;
    while (!SR_CK && k < 200) begin
      cyc();
      k++;
    end
    chk("saw_shift_hi", 32'(SR_CK), 1);
    RESET = 1;
    enable = 0;
    cyc();
    chk_reset_outputs();
    RESET = 0;
    enable = 1;
    run_fs(2);
    commit_req = 1;
    wait_ack("ack_after_reset", k);
    commit_req = 0;
    run_fs(1);
    chk("cleared_slot0", 32'(lat_vec[0]), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
